wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
Two-master, one-slave Wishbone classic arbiter that shares the single Wishbone bus driven by the AXI-stream-to-Wishbone bridge with a second requester, such as a debug or DMA master.
- Arbitration is round-robin.
- The grant is held for the whole CYC cycle.
- A watchdog terminates transfers the slave never acknowledges, returning an error to the owning master.
- Sits between the bridge's wb_* master port and the downstream slave or interconnect.

Parameters:
WB_DATA_WIDTH, 32, data bus width in bits (8/16/32/64)
WB_ADDR_WIDTH, 32, address bus width in bits
WB_SELECT_WIDTH, WB_DATA_WIDTH/8, byte-select width
TIMEOUT_CYCLES, 256, stalled-strobe cycles before forced error; 0 disables the watchdog
TIMEOUT_WIDTH, 16, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
m0_adr_i / m1_adr_i  in  WB_ADDR_WIDTH  master address
m0_dat_i / m1_dat_i  in  WB_DATA_WIDTH  master write data
m0_dat_o / m1_dat_o  out  WB_DATA_WIDTH  read data to master
m0_we_i / m1_we_i  in  1  write enable
m0_sel_i / m1_sel_i  in  WB_SELECT_WIDTH  byte select
m0_stb_i / m1_stb_i  in  1  strobe
m0_cyc_i / m1_cyc_i  in  1  cycle request
m0_ack_o / m1_ack_o  out  1  acknowledge
m0_err_o / m1_err_o  out  1  error
wb_adr_o  out  WB_ADDR_WIDTH  slave address
wb_dat_o  out  WB_DATA_WIDTH  slave write data
wb_dat_i  in  WB_DATA_WIDTH  slave read data
wb_we_o  out  1  slave write enable
wb_sel_o  out  WB_SELECT_WIDTH  slave byte select
wb_stb_o  out  1  slave strobe
wb_cyc_o  out  1  slave cycle
wb_ack_i  in  1  slave acknowledge
wb_err_i  in  1  slave error
gnt_o  out  2  registered one-hot grant; bit0 = m0, bit1 = m1
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (reset==0 at a rising edge) is synchronous and active-low. It forces:
  - state=IDLE, gnt_o=2'b00, last_owner=m1 so m0 wins the first contention
  - watchdog count=0, timeout_o=0
  - all wb_* outputs, and all mN_ack_o/err_o/dat_o, to 0
- Reset mid-transfer: wb_cyc_o/wb_stb_o fall in the same cycle the reset is sampled. Any in-flight slave ack is dropped.
- States are IDLE and BUSY. Owner is a register, 0 or 1.
- IDLE:
  - If exactly one mN_cyc_i is high, grant it at the next edge.
  - If both are high, grant the master that is not last_owner.
  - Arbitration latency is 1 cycle: a request sampled at edge N gives gnt_o and wb_cyc_o high after edge N.
- BUSY:
  - Slave outputs adr/dat/we/sel/stb/cyc are combinational copies of the owner's inputs, gated by the grant.
  - wb_ack_i, wb_err_i and wb_dat_i are routed only to the owner. The non-owner sees ack=0, err=0, dat=0.
- Release: the owner's cyc_i is low at an edge.
  - last_owner <= owner.
  - If the other master's cyc_i is high, owner flips and the state stays BUSY, giving a zero-idle-cycle handoff.
  - Otherwise the state goes to IDLE.
  - wb_cyc_o is low for at least one cycle between owners, because the owner's cyc is already low that cycle.
- A master that raises cyc_i while not granted must hold it. The arbiter never grants on stb_i alone.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counts cycles in BUSY with wb_stb_o=1 and wb_ack_i=0 and wb_err_i=0.
  - The count clears on ack, err, release or owner change.
  - When count==TIMEOUT_CYCLES-1 and the cycle is still stalled, the next cycle does all of the following:
    - drives owner err_o=1 for 1 cycle
    - forces wb_stb_o=0 for that cycle
    - pulses timeout_o=1
    - clears the count
- A real slave ack/err in the same cycle as the expiry wins: it is passed through, with no timeout and no synthesized err.
- With TIMEOUT_CYCLES==0 the counter is held at 0 and timeout_o is never asserted.
- Slave ack and err both high: both are passed through unchanged. Resolving that is a slave protocol violation, not arbitrated here.

Decomposition:
- Package wb_arb_pkg holds:
  - typedef enum {IDLE, BUSY} arb_state_t
  - typedef enum logic {OWN_M0, OWN_M1} owner_t
  - localparam for the reset last_owner
- Sub-module wb_arb_watchdog, parameterised by TIMEOUT_CYCLES and TIMEOUT_WIDTH:
  - inputs: clock, reset, enable (stalled), clear
  - output: expire pulse
- The top holds the FSM and the mux.

Test Plan:
- Single master: m0 issues a write with adr=0x0000_0010, dat=0xDEAD_BEEF, sel=4'hF; slave acks after 2 cycles -> gnt_o=01 one cycle after cyc; wb_adr_o/wb_dat_o match; m0_ack_o pulses once; m1_ack_o stays 0.
- Contention after reset: m0 and m1 raise cyc in the same cycle -> m0 granted first. After m0 drops cyc, gnt_o=10 on the next edge with no IDLE cycle. A second simultaneous request is then granted to m0 again, since last_owner=m1.
- Read routing: m1 reads 0x40, slave returns wb_dat_i=0x1234_5678 with ack -> m1_dat_o=0x1234_5678 and m1_ack_o=1; m0_dat_o=0 and m0_ack_o=0 throughout.
- Timeout: TIMEOUT_CYCLES=8, m0 strobes and the slave never acks -> exactly 8 stalled cycles, then m0_err_o=1 and timeout_o=1 for one cycle with wb_stb_o=0. Repeat with the slave ack arriving on the 8th cycle -> ack passed through, no err, no timeout_o.
- Reset mid-transfer: m1 granted with stb high; reset=0 for 1 cycle -> next cycle gnt_o=00, wb_cyc_o=0, watchdog cleared. After release, a simultaneous request is granted to m0.
- Slave error: slave asserts wb_err_i during an m0 cycle -> m0_err_o=1 that cycle, watchdog cleared, timeout_o=0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone round-robin arbiter.
// Holds the FSM state and owner encodings, the reset value of the
// last-owner register and a helper that turns an owner into a one-hot grant.
package wb_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef enum logic {OWN_M0, OWN_M1} owner_t;

  // m1 is recorded as the last owner out of reset so m0 wins the first contention
  localparam owner_t RESET_LAST_OWNER = OWN_M1;

  function automatic logic [1:0] owner_onehot(input owner_t own);
    return (own == OWN_M0) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog for the arbiter: counts consecutive stalled strobe cycles
// and emits a one-cycle expire pulse the cycle after the count reaches
// TIMEOUT_CYCLES-1 while still stalled. TIMEOUT_CYCLES==0 disables it.
// Ports:
//   clock     rising-edge clock
//   reset     synchronous active-low reset
//   enable_i  cycle is stalled (strobe out, no ack/err)
//   clear_i   restart the count (ack, err, release, owner change, idle)
//   expire_o  registered one-cycle expiry pulse
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic enable_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     exp_q, exp_d;

  // Next count / expiry; the expiry cycle itself also restarts the count
  always_comb begin
    cnt_d = cnt_q;
    exp_d = 1'b0;
    if (TIMEOUT_CYCLES == 0) begin
      cnt_d = '0;
    end else if (clear_i || exp_q) begin
      cnt_d = '0;
    end else if (enable_i) begin
      if (cnt_q == CNT_LAST) begin
        exp_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  end

  assign expire_o = exp_q;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master, one-slave Wishbone classic round-robin arbiter. The grant is
// held for a whole CYC; a watchdog turns a never-acknowledged strobe into an
// error back to the owning master.
// Ports:
//   clock, reset               rising-edge clock, synchronous active-low reset
//   m0_* / m1_*                master-side Wishbone ports
//   wb_*                       slave-side Wishbone port
//   gnt_o                      registered one-hot grant (bit0 = m0, bit1 = m1)
//   timeout_o                  one-cycle pulse when the watchdog fires
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned WB_DATA_WIDTH   = 32,
  parameter int unsigned WB_ADDR_WIDTH   = 32,
  parameter int unsigned WB_SELECT_WIDTH = WB_DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES  = 256,
  parameter int unsigned TIMEOUT_WIDTH   = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WB_ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]   m0_dat_i,
  output logic [WB_DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                       m0_we_i,
  input  logic [WB_SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                       m0_stb_i,
  input  logic                       m0_cyc_i,
  output logic                       m0_ack_o,
  output logic                       m0_err_o,
  input  logic [WB_ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [WB_DATA_WIDTH-1:0]   m1_dat_i,
  output logic [WB_DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                       m1_we_i,
  input  logic [WB_SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                       m1_stb_i,
  input  logic                       m1_cyc_i,
  output logic                       m1_ack_o,
  output logic                       m1_err_o,
  output logic [WB_ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [WB_DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [WB_DATA_WIDTH-1:0]   wb_dat_i,
  output logic                       wb_we_o,
  output logic [WB_SELECT_WIDTH-1:0] wb_sel_o,
  output logic                       wb_stb_o,
  output logic                       wb_cyc_o,
  input  logic                       wb_ack_i,
  input  logic                       wb_err_i,
  output logic [1:0]                 gnt_o,
  output logic                       timeout_o
);

  arb_state_t state_q, state_d;
  owner_t     owner_q, owner_d;
  owner_t     last_q, last_d;
  logic [1:0] gnt_q, gnt_d;

  logic own_cyc, oth_cyc, release_c;
  logic sel_m0, sel_m1;
  logic expire, stalled, wd_clear;

  assign own_cyc   = (owner_q == OWN_M0) ? m0_cyc_i : m1_cyc_i;
  assign oth_cyc   = (owner_q == OWN_M0) ? m1_cyc_i : m0_cyc_i;
  assign release_c = (state_q == BUSY) && !own_cyc;

  // Arbitration and release/handoff
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = 2'b00;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          owner_d = (last_q == OWN_M0) ? OWN_M1 : OWN_M0;
          state_d = BUSY;
        end else if (m0_cyc_i) begin
          owner_d = OWN_M0;
          state_d = BUSY;
        end else if (m1_cyc_i) begin
          owner_d = OWN_M1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          last_d = owner_q;
          if (oth_cyc) begin
            owner_d = (owner_q == OWN_M0) ? OWN_M1 : OWN_M0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == BUSY) begin
      gnt_d = owner_onehot(owner_d);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_M0;
      last_q  <= RESET_LAST_OWNER;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  // Reset is folded into the path select so the slave sees cyc/stb drop in
  // the very cycle reset is sampled, and any in-flight ack is discarded.
  assign sel_m0 = reset && gnt_q[0];
  assign sel_m1 = reset && gnt_q[1];

  assign wb_adr_o = sel_m0 ? m0_adr_i : (sel_m1 ? m1_adr_i : '0);
  assign wb_dat_o = sel_m0 ? m0_dat_i : (sel_m1 ? m1_dat_i : '0);
  assign wb_sel_o = sel_m0 ? m0_sel_i : (sel_m1 ? m1_sel_i : '0);
  assign wb_we_o  = (sel_m0 && m0_we_i) || (sel_m1 && m1_we_i);
  assign wb_cyc_o = (sel_m0 && m0_cyc_i) || (sel_m1 && m1_cyc_i);
  // Strobe is withdrawn for the single cycle in which the timeout error is returned
  assign wb_stb_o = ((sel_m0 && m0_cyc_i && m0_stb_i) ||
                     (sel_m1 && m1_cyc_i && m1_stb_i)) && !expire;

  assign m0_ack_o = sel_m0 && wb_ack_i;
  assign m1_ack_o = sel_m1 && wb_ack_i;
  assign m0_err_o = sel_m0 && (wb_err_i || expire);
  assign m1_err_o = sel_m1 && (wb_err_i || expire);
  assign m0_dat_o = sel_m0 ? wb_dat_i : '0;
  assign m1_dat_o = sel_m1 ? wb_dat_i : '0;

  assign gnt_o = gnt_q;

  // A real ack/err in the expiry cycle means the cycle is not stalled, so it wins
  assign stalled  = (state_q == BUSY) && wb_stb_o && !wb_ack_i && !wb_err_i;
  assign wd_clear = (state_q != BUSY) || release_c || wb_ack_i || wb_err_i;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .enable_i (stalled),
    .clear_i  (wd_clear),
    .expire_o (expire)
  );

  assign timeout_o = expire;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter with an 8-cycle watchdog.
module tb_wb_rr_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned TO = 8;

  logic clock = 1'b0;
  logic reset;

  logic [AW-1:0] m0_adr_i, m1_adr_i, wb_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, wb_dat_o, wb_dat_i;
  logic          m0_we_i, m1_we_i, wb_we_o;
  logic [SW-1:0] m0_sel_i, m1_sel_i, wb_sel_o;
  logic          m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i;
  logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic          wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i;
  logic [1:0]    gnt_o;
  logic          timeout_o;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  wb_rr_arbiter #(
    .WB_DATA_WIDTH   (DW),
    .WB_ADDR_WIDTH   (AW),
    .WB_SELECT_WIDTH (SW),
    .TIMEOUT_CYCLES  (TO),
    .TIMEOUT_WIDTH   (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .m0_adr_i  (m0_adr_i),
    .m0_dat_i  (m0_dat_i),
    .m0_dat_o  (m0_dat_o),
    .m0_we_i   (m0_we_i),
    .m0_sel_i  (m0_sel_i),
    .m0_stb_i  (m0_stb_i),
    .m0_cyc_i  (m0_cyc_i),
    .m0_ack_o  (m0_ack_o),
    .m0_err_o  (m0_err_o),
    .m1_adr_i  (m1_adr_i),
    .m1_dat_i  (m1_dat_i),
    .m1_dat_o  (m1_dat_o),
    .m1_we_i   (m1_we_i),
    .m1_sel_i  (m1_sel_i),
    .m1_stb_i  (m1_stb_i),
    .m1_cyc_i  (m1_cyc_i),
    .m1_ack_o  (m1_ack_o),
    .m1_err_o  (m1_err_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o),
    .wb_stb_o  (wb_stb_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .gnt_o     (gnt_o),
    .timeout_o (timeout_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_sel_i = '0; m0_stb_i = 1'b0; m0_cyc_i = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_sel_i = '0; m1_stb_i = 1'b0; m1_cyc_i = 1'b0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    #1;
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
    chk("rst_stb", 64'(wb_stb_o), 64'd0);
    chk("rst_m0_ack", 64'(m0_ack_o), 64'd0);
    chk("rst_m1_err", 64'(m1_err_o), 64'd0);
    reset = 1'b1;

    // Single master write, slave acks two cycles after grant
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
    m0_adr_i = 32'h0000_0010; m0_dat_i = 32'hDEAD_BEEF; m0_sel_i = 4'hF;
    #1;
    chk("wr_pre_gnt", 64'(gnt_o), 64'd0);
    chk("wr_pre_cyc", 64'(wb_cyc_o), 64'd0);
    step(); #1;
    chk("wr_gnt", 64'(gnt_o), 64'h1);
    chk("wr_cyc", 64'(wb_cyc_o), 64'd1);
    chk("wr_stb", 64'(wb_stb_o), 64'd1);
    chk("wr_adr", 64'(wb_adr_o), 64'h10);
    chk("wr_dat", 64'(wb_dat_o), 64'hDEAD_BEEF);
    chk("wr_sel", 64'(wb_sel_o), 64'hF);
    chk("wr_we", 64'(wb_we_o), 64'd1);
    chk("wr_ack_early", 64'(m0_ack_o), 64'd0);
    step(); #1;
    chk("wr_ack_wait", 64'(m0_ack_o), 64'd0);
    step();
    wb_ack_i = 1'b1;
    #1;
    chk("wr_m0_ack", 64'(m0_ack_o), 64'd1);
    chk("wr_m1_ack", 64'(m1_ack_o), 64'd0);
    step();
    wb_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #1;
    chk("wr_ack_once", 64'(m0_ack_o), 64'd0);
    chk("wr_rel_cyc", 64'(wb_cyc_o), 64'd0);
    step(); #1;
    chk("wr_idle_gnt", 64'(gnt_o), 64'd0);

    // Contention after reset, zero-idle handoff, then m0 again
    idle_inputs();
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h100;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h200;
    step(); #1;
    chk("ct_gnt_m0", 64'(gnt_o), 64'h1);
    chk("ct_adr_m0", 64'(wb_adr_o), 64'h100);
    step();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #1;
    chk("ct_rel_cyc", 64'(wb_cyc_o), 64'd0);
    step(); #1;
    chk("ct_gnt_m1", 64'(gnt_o), 64'h2);
    chk("ct_adr_m1", 64'(wb_adr_o), 64'h200);
    chk("ct_cyc_m1", 64'(wb_cyc_o), 64'd1);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step(); #1;
    chk("ct_idle", 64'(gnt_o), 64'd0);
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    step(); #1;
    chk("ct_regrant_m0", 64'(gnt_o), 64'h1);
    m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;

    // Read routing to m1 only
    idle_inputs();
    do_reset();
    wb_dat_i = 32'h1234_5678;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 32'h40; m1_sel_i = 4'hF;
    #1;
    chk("rd_pre_m1_dat", 64'(m1_dat_o), 64'd0);
    step(); #1;
    chk("rd_gnt", 64'(gnt_o), 64'h2);
    chk("rd_adr", 64'(wb_adr_o), 64'h40);
    chk("rd_we", 64'(wb_we_o), 64'd0);
    step();
    wb_ack_i = 1'b1;
    #1;
    chk("rd_m1_dat", 64'(m1_dat_o), 64'h1234_5678);
    chk("rd_m1_ack", 64'(m1_ack_o), 64'd1);
    chk("rd_m0_dat", 64'(m0_dat_o), 64'd0);
    chk("rd_m0_ack", 64'(m0_ack_o), 64'd0);
    step();
    idle_inputs();
    step();

    // Watchdog fires after exactly 8 stalled cycles
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h80;
    for (int i = 0; i < 8; i++) begin
      step(); #1;
      chk($sformatf("to_stall%0d_stb", i), 64'(wb_stb_o), 64'd1);
      chk($sformatf("to_stall%0d_tmo", i), 64'(timeout_o), 64'd0);
      chk($sformatf("to_stall%0d_err", i), 64'(m0_err_o), 64'd0);
    end
    step(); #1;
    chk("to_fire_tmo", 64'(timeout_o), 64'd1);
    chk("to_fire_err", 64'(m0_err_o), 64'd1);
    chk("to_fire_stb", 64'(wb_stb_o), 64'd0);
    chk("to_fire_cyc", 64'(wb_cyc_o), 64'd1);
    chk("to_fire_m1_err", 64'(m1_err_o), 64'd0);
    step(); #1;
    chk("to_after_tmo", 64'(timeout_o), 64'd0);
    chk("to_after_err", 64'(m0_err_o), 64'd0);
    chk("to_after_stb", 64'(wb_stb_o), 64'd1);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();

    // Ack on the 8th stalled cycle wins over the timeout
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    step(); #1;
    chk("ta_gnt", 64'(gnt_o), 64'h1);
    for (int i = 1; i < 7; i++) begin
      step(); #1;
      chk($sformatf("ta_stall%0d_tmo", i), 64'(timeout_o), 64'd0);
    end
    step();
    wb_ack_i = 1'b1;
    #1;
    chk("ta_ack", 64'(m0_ack_o), 64'd1);
    chk("ta_ack_err", 64'(m0_err_o), 64'd0);
    step();
    wb_ack_i = 1'b0;
    #1;
    chk("ta_no_tmo", 64'(timeout_o), 64'd0);
    chk("ta_no_err", 64'(m0_err_o), 64'd0);
    chk("ta_stb", 64'(wb_stb_o), 64'd1);
    idle_inputs();
    step();

    // Reset in the middle of an m1 transfer
    do_reset();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'hC0;
    step(); #1;
    chk("rm_gnt", 64'(gnt_o), 64'h2);
    repeat (5) step();
    reset = 1'b0;
    #1;
    chk("rm_cyc_drop", 64'(wb_cyc_o), 64'd0);
    chk("rm_stb_drop", 64'(wb_stb_o), 64'd0);
    step();
    reset = 1'b1; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    #1;
    chk("rm_gnt_clr", 64'(gnt_o), 64'd0);
    chk("rm_cyc_clr", 64'(wb_cyc_o), 64'd0);
    chk("rm_tmo_clr", 64'(timeout_o), 64'd0);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    step(); #1;
    chk("rm_regrant_m0", 64'(gnt_o), 64'h1);
    for (int i = 1; i < 8; i++) begin
      step(); #1;
      chk($sformatf("rm_stall%0d_tmo", i), 64'(timeout_o), 64'd0);
    end
    idle_inputs();
    step(); #1;
    chk("rm_idle", 64'(gnt_o), 64'd0);

    // Slave error passes through and restarts the watchdog
    do_reset();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    step(); #1;
    chk("se_gnt", 64'(gnt_o), 64'h1);
    repeat (3) step();
    step();
    wb_err_i = 1'b1;
    #1;
    chk("se_err", 64'(m0_err_o), 64'd1);
    chk("se_ack", 64'(m0_ack_o), 64'd0);
    chk("se_tmo", 64'(timeout_o), 64'd0);
    chk("se_m1_err", 64'(m1_err_o), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      wb_err_i = 1'b0;
      #1;
      chk($sformatf("se_stall%0d_tmo", i), 64'(timeout_o), 64'd0);
    end
    step(); #1;
    chk("se_late_tmo", 64'(timeout_o), 64'd1);
    chk("se_late_err", 64'(m0_err_o), 64'd1);
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
